// File: rtl/vector_scalar_reduce_unit.sv
// vector_scalar_reduce_unit: per-chain PASS / lane-SUM / frame-ACCUM of a vector stream, fixed 2-cycle latency.
module vector_scalar_reduce_unit #(
    parameter int N = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_OP = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tracing,
    input  logic                               valid_in,
    input  logic [1:0]                         eof_in,
    input  logic [1:0]                         bof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0]      chainId_in,
    input  logic [7:0]                         configId,
    input  logic [7:0]                         configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]       vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0]       vector_out,
    output logic [$clog2(MAX_CHAINS)-1:0]      chainId_out,
    output logic                               valid_out,
    output logic [1:0]                         eof_out,
    output logic [1:0]                         bof_out
);
    localparam int CW = $clog2(MAX_CHAINS);
    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

    logic [MAX_CHAINS-1:0][7:0] fw_op;
    vec_t [MAX_CHAINS-1:0]      acc;
    logic [7:0]                 byte_counter;
    logic [7:0]                 op;
    logic [DATA_WIDTH-1:0]      sum;
    vec_t                       acc_nxt;
    vec_t                       s1_vec_d;
    vec_t                       s1_vec;
    logic                       s1_valid_d;
    logic                       s1_valid;
    logic [1:0]                 s1_eof;
    logic [1:0]                 s1_bof;
    logic [CW-1:0]              s1_chain;

    always_comb begin
        op = fw_op[chainId_in];
        sum = '0;
        acc_nxt = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + vector_in[i];
            acc_nxt[i] = (bof_in[0] ? '0 : acc[chainId_in][i]) + vector_in[i];
        end
        s1_vec_d = op == 8'd1 ? vec_t'(sum) : op == 8'd2 ? acc_nxt : vector_in;
        s1_valid_d = valid_in && tracing && (op != 8'd2 || eof_in[0]);
    end

    // Accumulators update at stage 1, so a same-chain vector next cycle already sees the new sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fw_op        <= INITIAL_FIRMWARE_OP;
            acc          <= '0;
            byte_counter <= '0;
            s1_vec       <= '0;
            s1_valid     <= 1'b0;
            s1_eof       <= '0;
            s1_bof       <= '0;
            s1_chain     <= '0;
            vector_out   <= '0;
            valid_out    <= 1'b0;
            eof_out      <= '0;
            bof_out      <= '0;
            chainId_out  <= '0;
        end else begin
            s1_vec      <= s1_vec_d;
            s1_valid    <= s1_valid_d;
            s1_eof      <= eof_in;
            s1_bof      <= bof_in;
            s1_chain    <= chainId_in;
            vector_out  <= s1_vec;
            valid_out   <= s1_valid && tracing;
            eof_out     <= s1_eof;
            bof_out     <= s1_bof;
            chainId_out <= s1_chain;
            if (tracing && valid_in && op == 8'd2)
                acc[chainId_in] <= eof_in[0] ? '0 : acc_nxt;
            if (!tracing) begin
                if (configId == 8'(PERSONAL_CONFIG_ID)) begin
                    if (int'(byte_counter) < MAX_CHAINS) begin
                        fw_op[byte_counter[CW-1:0]] <= configData;
                        acc[byte_counter[CW-1:0]]   <= '0;
                    end
                    byte_counter <= byte_counter == 8'hFF ? byte_counter : byte_counter + 8'd1;
                end else begin
                    byte_counter <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vector_scalar_reduce_unit.sv
// tb_vector_scalar_reduce_unit: directed plus random stream checked against a behavioural model.
module tb_vector_scalar_reduce_unit;
    typedef logic [7:0][31:0] vec_t;
    typedef struct {
        logic       v;
        vec_t       d;
        logic [1:0] c;
        logic [1:0] e;
        logic [1:0] b;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tracing = 1'b1;
    logic       valid_in = 1'b0;
    logic [1:0] eof_in = '0;
    logic [1:0] bof_in = '0;
    logic [1:0] chainId_in = '0;
    logic [7:0] configId = 8'hAA;
    logic [7:0] configData = '0;
    vec_t       vector_in = '0;
    vec_t       vector_out;
    logic [1:0] chainId_out;
    logic       valid_out;
    logic [1:0] eof_out;
    logic [1:0] bof_out;

    int checks = 0;
    int failures = 0;

    logic [3:0][7:0]  m_op;
    vec_t [3:0]       m_acc;
    int               m_bc;
    ent_t             p1;

    vector_scalar_reduce_unit dut (
        .clk(clk), .rst(rst), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
        .configId(configId), .configData(configData), .vector_in(vector_in),
        .vector_out(vector_out), .chainId_out(chainId_out), .valid_out(valid_out),
        .eof_out(eof_out), .bof_out(bof_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t fill(input logic [31:0] x);
        vec_t r;
        for (int i = 0; i < 8; i++) r[i] = x;
        return r;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t r;
        for (int i = 0; i < 8; i++) r[i] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_op = '0;
        m_acc = '0;
        m_bc = 0;
        p1 = '{v: 1'b0, d: '0, c: '0, e: '0, b: '0};
    endtask

    // One clock: drive inputs, predict stage-1 result, compare outputs of the previous input.
    task automatic step(input logic tr, input logic vi, input logic [1:0] e, input logic [1:0] b,
                        input logic [1:0] c, input logic [7:0] cid, input logic [7:0] cdat, input vec_t v);
        ent_t n;
        logic [31:0] s;
        tracing = tr; valid_in = vi; eof_in = e; bof_in = b; chainId_in = c;
        configId = cid; configData = cdat; vector_in = v;
        n = '{v: 1'b0, d: '0, c: c, e: e, b: b};
        if (tr) begin
            if (m_op[c] == 8'd1) begin
                s = 0;
                for (int i = 0; i < 8; i++) s += v[i];
                n.d[0] = s;
                n.v = vi;
            end else if (m_op[c] == 8'd2) begin
                if (vi) begin
                    if (b[0]) m_acc[c] = '0;
                    for (int i = 0; i < 8; i++) m_acc[c][i] = m_acc[c][i] + v[i];
                    if (e[0]) begin
                        n.d = m_acc[c];
                        n.v = 1'b1;
                        m_acc[c] = '0;
                    end
                end
            end else begin
                n.d = v;
                n.v = vi;
            end
        end else if (cid == 8'd0) begin
            if (m_bc < 4) begin
                m_op[m_bc] = cdat;
                m_acc[m_bc] = '0;
            end
            if (m_bc < 255) m_bc++;
        end else begin
            m_bc = 0;
        end
        @(posedge clk);
        #1;
        chk("valid_out", 256'(valid_out), 256'(p1.v & tr));
        chk("chainId_out", 256'(chainId_out), 256'(p1.c));
        chk("eof_out", 256'(eof_out), 256'(p1.e));
        chk("bof_out", 256'(bof_out), 256'(p1.b));
        if (p1.v & tr) chk("vector_out", vector_out, p1.d);
        p1 = n;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'b00, 2'b00, 2'd0, 8'hAA, 8'h00, '0);
    endtask

    task automatic cfg(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        logic [3:0][7:0] bytes;
        bytes = {b3, b2, b1, b0};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b01, 2'b01, 2'(i), 8'd0, bytes[i], rnd_vec());
        step(1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 8'd0, 8'h02, rnd_vec());
        step(1'b0, 1'b0, 2'b00, 2'b00, 2'd0, 8'h55, 8'h00, '0);
    endtask

    task automatic acc_step(input logic [1:0] c, input logic bof, input logic eof, input logic [31:0] x);
        step(1'b1, 1'b1, {1'b0, eof}, {1'b1, bof}, c, 8'hAA, 8'h00, fill(x));
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 256'(valid_out), 256'(0));
        chk("rst_vector", vector_out, 256'(0));
        chk("rst_flags", 256'({eof_out, bof_out, chainId_out}), 256'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t ramp;
        model_reset();
        #12;
        chk("reset_valid", 256'(valid_out), 256'(0));
        chk("reset_vector", vector_out, 256'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) ramp[i] = i;
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'd0, 8'hAA, 8'h00, ramp);
        chk("pass_not_yet", 256'(valid_out), 256'(0));
        idle();
        chk("pass_valid", 256'(valid_out), 256'(1));
        chk("pass_vec", vector_out, ramp);
        idle();

        cfg(8'd1, 8'd2, 8'd0, 8'd0);
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'd0, 8'hAA, 8'h00, fill(32'd3));
        idle();
        chk("cfg_sum_chain0", vector_out, 256'(32'd24));

        cfg(8'd0, 8'd1, 8'd2, 8'd2);
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'd1, 8'hAA, 8'h00, fill(32'hFFFFFFFF));
        idle();
        chk("sum_ones", vector_out, 256'(32'hFFFFFFF8));
        chk("sum_valid", 256'(valid_out), 256'(1));

        acc_step(2'd2, 1'b1, 1'b0, 32'd1);
        acc_step(2'd2, 1'b0, 1'b0, 32'd1);
        acc_step(2'd2, 1'b0, 1'b1, 32'd1);
        chk("acc_none_before", 256'(valid_out), 256'(0));
        idle();
        chk("acc3", vector_out, fill(32'd3));

        for (int k = 0; k < 4; k++) begin
            acc_step(2'd2, k == 0, k == 3, 32'd1);
            acc_step(2'd3, k == 0, k == 3, 32'd10);
        end
        chk("interleave_c2", vector_out, fill(32'd4));
        idle();
        chk("interleave_c3", vector_out, fill(32'd40));

        acc_step(2'd2, 1'b0, 1'b1, 32'd7);
        idle();
        chk("acc_single", vector_out, fill(32'd7));

        acc_step(2'd2, 1'b1, 1'b0, 32'd5);
        acc_step(2'd2, 1'b0, 1'b0, 32'd5);
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'd0, 8'hAA, 8'h00, fill(32'h1234));
        idle();
        pulse_reset();
        cfg(8'd0, 8'd1, 8'd2, 8'd2);
        acc_step(2'd2, 1'b0, 1'b0, 32'd5);
        acc_step(2'd2, 1'b0, 1'b1, 32'd5);
        idle();
        chk("acc_after_reset", vector_out, fill(32'd10));

        cfg(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'd2, 8'd2);
        for (int k = 0; k < 600; k++) begin
            logic tr;
            tr = $urandom_range(0, 15) != 0;
            step(tr, 1'($urandom_range(0, 3) != 0),
                 {1'($urandom), 1'($urandom_range(0, 3) == 0)},
                 {1'($urandom), 1'($urandom_range(0, 3) == 0)},
                 2'($urandom), $urandom_range(0, 5) == 0 ? 8'd0 : 8'h33,
                 8'($urandom_range(0, 3)), rnd_vec());
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
